// File: rtl/timer_multi.sv
// timer_multi: multi-channel Avalon-MM interval timer.
// Prescaled down-counters with snapshot, status and one combined irq.
module timer_multi #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h0001D4BF,
  parameter int          PRE_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_CNT =
    RESET_PERIOD[CNT_W-1:0];

  logic              wr_en;
  logic [1:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic [31:0]       st_rd   [NUM_CH];
  logic [31:0]       ctl_rd  [NUM_CH];
  logic [31:0]       per_rd  [NUM_CH];
  logic [31:0]       snap_rd [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;
  logic [31:0]       rd_next;
  logic              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign ch_sel    = address[3:2];
  assign reg_sel   = address[1:0];
  assign irq       = |irq_vec;
  assign unused_wd = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] snap_q;
    logic [PRE_W-1:0] pcnt_q;
    logic [PRE_W-1:0] pre_q;
    logic             to_q;
    logic             run_q;
    logic             ito_q;
    logic             cont_q;
    logic             reload_q;
    logic             sel;
    logic             wr_st;
    logic             wr_ctl;
    logic             wr_per;
    logic             wr_snap;
    logic             tick;
    logic             tmo;

    assign sel     = wr_en && (ch_sel == 2'(i));
    assign wr_st   = sel && (reg_sel == 2'd0);
    assign wr_ctl  = sel && (reg_sel == 2'd1);
    assign wr_per  = sel && (reg_sel == 2'd2);
    assign wr_snap = sel && (reg_sel == 2'd3);
    assign tick    = run_q && (pcnt_q == pre_q);
    assign tmo     = tick && (cnt_q == '0);

    assign st_rd[i]   = {30'd0, run_q, to_q};
    assign ctl_rd[i]  = 32'({pre_q, 6'd0, cont_q, ito_q});
    assign per_rd[i]  = 32'(per_q);
    assign snap_rd[i] = 32'(snap_q);
    assign irq_vec[i] = to_q & ito_q;

    // channel state: prescaler, counter, timeout, bus writes
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q    <= RST_CNT;
        per_q    <= RST_CNT;
        snap_q   <= '0;
        pcnt_q   <= '0;
        pre_q    <= '0;
        to_q     <= 1'b0;
        run_q    <= 1'b0;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        reload_q <= 1'b0;
      end else begin
        if (run_q)
          pcnt_q <= tick ? '0 : pcnt_q + PRE_W'(1);
        if (tick)
          cnt_q <= tmo ? per_q : cnt_q - CNT_W'(1);
        if (tmo && !cont_q)
          run_q <= 1'b0;
        if (tmo)
          to_q <= 1'b1;
        else if (wr_st)
          to_q <= 1'b0;
        reload_q <= wr_per;
        if (reload_q) begin
          cnt_q  <= per_q;
          pcnt_q <= '0;
        end
        if (wr_per)
          per_q <= writedata[CNT_W-1:0];
        if (wr_ctl) begin
          ito_q  <= writedata[0];
          cont_q <= writedata[1];
          pre_q  <= writedata[8 +: PRE_W];
          if (writedata[2]) begin
            run_q  <= 1'b1;
            pcnt_q <= '0;
          end else if (writedata[3]) begin
            run_q <= 1'b0;
          end
        end
        if (wr_snap)
          snap_q <= cnt_q;
      end
    end
  end

  // read mux; absent channels read as zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 2'(i)) begin
        unique case (reg_sel)
          2'd0: rd_next = st_rd[i];
          2'd1: rd_next = ctl_rd[i];
          2'd2: rd_next = per_rd[i];
          2'd3: rd_next = snap_rd[i];
        endcase
      end
    end
  end

  // one-cycle registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

endmodule
